bilstm_batch_sequencer: RTL and testbench

- Batch-level controller for the BiLSTM top.
- Each batch: accepts a stream of 60 input samples and writes them into the BiLSTM input memory, pulses start_bilstm, waits for done_store_concat, then reads the 200-word concat memory and streams it downstream with valid/ready.
- Repeats for NUM_BATCHES batches per run; this block replaces the bench-driven load/start/readout sequence.

---
 rtl/bilstm_seq_pkg.sv | 27 ++
 rtl/seq_out_fifo2.sv | 67 ++++++
 rtl/bilstm_batch_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_bilstm_batch_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bilstm_seq_pkg.sv
// -----------------------------------------------------------------------------
// bilstm_seq_pkg
// Shared definitions for the BiLSTM batch sequencer:
//   - seq_state_t : controller states (IDLE, LOAD, START, WAIT, DRAIN)
//   - default element counts and their last-index constants
//   - last_index(): helper used to derive terminal counter values
// -----------------------------------------------------------------------------
package bilstm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } seq_state_t;

    localparam int DEF_IN_ELEMS  = 60;
    localparam int DEF_OUT_ELEMS = 200;
    localparam int DEF_IN_LAST   = DEF_IN_ELEMS - 1;
    localparam int DEF_OUT_LAST  = DEF_OUT_ELEMS - 1;

    function automatic int last_index(input int elems);
        return elems - 1;
    endfunction

endpackage

// File: rtl/seq_out_fifo2.sv
// -----------------------------------------------------------------------------
// seq_out_fifo2
// Two-entry valid/ready buffer between the concat memory read port and the
// downstream stream. A push into a full buffer is accepted only when a pop
// happens in the same cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        synchronous clear of occupancy and pointers
//   push         write push_data (ignored when full without a pop)
//   push_data    entry to store
//   pop          downstream ready; consumes the head entry when valid
//   out_valid    head entry present
//   out_data     head entry, held stable until popped
//   count        occupancy (0..2), used for read-issue gating
// -----------------------------------------------------------------------------
module seq_out_fifo2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             do_pop;
    logic             do_push;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;
    assign do_pop    = pop && out_valid;
    assign do_push   = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bilstm_batch_sequencer.sv
// -----------------------------------------------------------------------------
// bilstm_batch_sequencer
// Batch-level controller for the BiLSTM top. Per batch it loads IN_ELEMS
// samples into the BiLSTM input memory, pulses start_bilstm, waits for a
// rising edge of done_store_concat, then streams OUT_ELEMS concat words out
// through a 2-entry buffer. Runs NUM_BATCHES batches per run pulse.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   run, abort                    run start (IDLE only), synchronous abort
//   in_valid/in_data/in_ready     input sample stream
//   input_write_*                 BiLSTM input memory write port (registered)
//   start_bilstm                  one-cycle start pulse
//   done_store_concat             BiLSTM batch-complete level
//   concat_mem_read_*             concat memory read port (1-cycle latency)
//   out_valid/out_data/out_last   output stream, out_ready backpressure
//   busy, batch_idx, run_done     status
// -----------------------------------------------------------------------------
module bilstm_batch_sequencer
    import bilstm_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int IN_ELEMS        = DEF_IN_ELEMS,
    parameter int IN_ADDR_WIDTH   = 6,
    parameter int OUT_ELEMS       = DEF_OUT_ELEMS,
    parameter int OUT_ADDR_WIDTH  = 8,
    parameter int NUM_BATCHES     = 20,
    parameter int BATCH_CNT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       input_write_enable,
    output logic [IN_ADDR_WIDTH-1:0]   input_write_address,
    output logic [DATA_WIDTH-1:0]      input_write_data,
    output logic                       start_bilstm,
    input  logic                       done_store_concat,
    output logic                       concat_mem_read_enable,
    output logic [OUT_ADDR_WIDTH-1:0]  concat_mem_read_address,
    input  logic [DATA_WIDTH-1:0]      concat_mem_read_data,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [BATCH_CNT_WIDTH-1:0] batch_idx,
    output logic                       run_done
);

    localparam logic [IN_ADDR_WIDTH-1:0]   IN_LAST    = IN_ADDR_WIDTH'(last_index(IN_ELEMS));
    localparam logic [OUT_ADDR_WIDTH-1:0]  OUT_LAST   = OUT_ADDR_WIDTH'(last_index(OUT_ELEMS));
    localparam logic [BATCH_CNT_WIDTH-1:0] BATCH_LAST = BATCH_CNT_WIDTH'(last_index(NUM_BATCHES));

    seq_state_t                state;
    logic [IN_ADDR_WIDTH-1:0]  wr_cnt;
    logic [OUT_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_all;
    logic                      rd_vld_p1;
    logic                      rd_last_p1;
    logic                      done_prev;
    logic [1:0]                fifo_count;
    logic                      fifo_valid;
    logic [DATA_WIDTH:0]       fifo_data;
    logic                      in_beat;
    logic                      pop;
    logic                      issue;
    logic                      done_rise;
    logic [2:0]                occ;

    assign in_ready  = (state == LOAD);
    assign in_beat   = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign done_rise = done_store_concat && !done_prev;
    assign pop       = fifo_valid && out_ready;

    // Occupancy seen by the issue gate: buffered words plus the read returning
    // this cycle, minus the word leaving this cycle. Crediting the pop keeps
    // one word per cycle flowing with out_ready held high.
    assign occ   = {1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign issue = (state == DRAIN) && !rd_all && !abort && (occ < 3'd2);

    assign concat_mem_read_enable  = issue;
    assign concat_mem_read_address = rd_addr;

    assign out_valid = fifo_valid;
    assign out_data  = fifo_data[DATA_WIDTH-1:0];
    assign out_last  = fifo_valid && fifo_data[DATA_WIDTH];

    // Stage p1: read data returns one cycle after issue and enters the buffer
    seq_out_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (rd_vld_p1),
        .push_data ({rd_last_p1, concat_mem_read_data}),
        .pop       (out_ready),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            wr_cnt              <= '0;
            rd_addr             <= '0;
            rd_all              <= 1'b0;
            rd_vld_p1           <= 1'b0;
            rd_last_p1          <= 1'b0;
            done_prev           <= 1'b0;
            input_write_enable  <= 1'b0;
            input_write_address <= '0;
            input_write_data    <= '0;
            start_bilstm        <= 1'b0;
            batch_idx           <= '0;
            run_done            <= 1'b0;
        end else begin
            done_prev          <= done_store_concat;
            input_write_enable <= 1'b0;
            start_bilstm       <= 1'b0;
            run_done           <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                wr_cnt     <= '0;
                rd_addr    <= '0;
                rd_all     <= 1'b0;
                rd_vld_p1  <= 1'b0;
                rd_last_p1 <= 1'b0;
                batch_idx  <= '0;
            end else begin
                rd_vld_p1 <= issue;
                if (issue) begin
                    rd_last_p1 <= (rd_addr == OUT_LAST);
                    if (rd_addr == OUT_LAST) rd_all <= 1'b1;
                    else                     rd_addr <= rd_addr + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (run) begin
                            state     <= LOAD;
                            batch_idx <= '0;
                            wr_cnt    <= '0;
                        end
                    end
                    LOAD: begin
                        if (in_beat) begin
                            input_write_enable  <= 1'b1;
                            input_write_address <= wr_cnt;
                            input_write_data    <= in_data;
                            if (wr_cnt == IN_LAST) begin
                                state        <= START;
                                start_bilstm <= 1'b1;
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    START: state <= WAIT;
                    WAIT: begin
                        if (done_rise) begin
                            state   <= DRAIN;
                            rd_addr <= '0;
                            rd_all  <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (pop && out_last) begin
                            batch_idx <= batch_idx + 1'b1;
                            rd_addr   <= '0;
                            rd_all    <= 1'b0;
                            if (batch_idx == BATCH_LAST) begin
                                state    <= IDLE;
                                run_done <= 1'b1;
                            end else begin
                                state  <= LOAD;
                                wr_cnt <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bilstm_batch_sequencer.sv
module tb_bilstm_batch_sequencer;

    localparam int DW  = 16;
    localparam int IAW = 6;
    localparam int OAW = 8;
    localparam int NB  = 2;
    localparam int BCW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic           abort = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           input_write_enable;
    logic [IAW-1:0] input_write_address;
    logic [DW-1:0]  input_write_data;
    logic           start_bilstm;
    logic           done_store_concat = 1'b0;
    logic           concat_mem_read_enable;
    logic [OAW-1:0] concat_mem_read_address;
    logic [DW-1:0]  concat_mem_read_data = '0;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           out_ready = 1'b0;
    logic           busy;
    logic [BCW-1:0] batch_idx;
    logic           run_done;

    bilstm_batch_sequencer #(
        .DATA_WIDTH(DW), .IN_ELEMS(60), .IN_ADDR_WIDTH(IAW), .OUT_ELEMS(200),
        .OUT_ADDR_WIDTH(OAW), .NUM_BATCHES(NB), .BATCH_CNT_WIDTH(BCW)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .input_write_enable(input_write_enable), .input_write_address(input_write_address),
        .input_write_data(input_write_data), .start_bilstm(start_bilstm),
        .done_store_concat(done_store_concat),
        .concat_mem_read_enable(concat_mem_read_enable),
        .concat_mem_read_address(concat_mem_read_address),
        .concat_mem_read_data(concat_mem_read_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .batch_idx(batch_idx), .run_done(run_done)
    );

    always #5 clk = ~clk;

    // Concat memory model: data = address + 0x100, one cycle after the strobe
    always @(posedge clk)
        if (concat_mem_read_enable)
            concat_mem_read_data <= 16'h0100 + {8'h00, concat_mem_read_address};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    int wr_n, start_n, rdone_n, iss_n, acc_n, out_n, last_n, max_out, stall_bad;
    logic [IAW-1:0] wr_addr_log [64];
    logic [DW-1:0]  wr_data_log [64];
    logic [DW-1:0]  out_log     [256];
    logic           last_log    [256];
    logic           prev_stall;
    logic [DW-1:0]  prev_data;
    logic           beat_seen;

    task automatic clear_logs();
        wr_n = 0; start_n = 0; rdone_n = 0; iss_n = 0; acc_n = 0;
        out_n = 0; last_n = 0; max_out = 0; stall_bad = 0;
        prev_stall = 1'b0; prev_data = '0; beat_seen = 1'b0;
    endtask

    task automatic observe();
        beat_seen = in_valid && in_ready;
        if (input_write_enable) begin
            if (wr_n < 64) begin
                wr_addr_log[wr_n] = input_write_address;
                wr_data_log[wr_n] = input_write_data;
            end
            wr_n++;
        end
        if (start_bilstm) start_n++;
        if (run_done) rdone_n++;
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            if (out_n < 256) begin
                out_log[out_n]  = out_data;
                last_log[out_n] = out_last;
            end
            if (out_last) last_n++;
            out_n++;
            acc_n++;
        end
        if (concat_mem_read_enable) iss_n++;
        if (iss_n - acc_n > max_out) max_out = iss_n - acc_n;
    endtask

    // Inputs change 1 time unit after posedge; outputs are observed at negedge
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic load_samples(input bit gaps, output int sent);
        int guard = 0;
        sent = 0;
        while (sent < 60 && guard < 1000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = DW'(sent);
            tick();
            if (beat_seen) sent++;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int target, output bit ok);
        int guard = 0;
        while (start_n < target && guard < 20) begin
            tick();
            guard++;
        end
        ok = (start_n >= target);
    endtask

    task automatic drain(input bit bp, input int target, output int cycles);
        cycles = 0;
        while (out_n < target && cycles < 2000) begin
            case (cycles % 4)
                1, 2:    out_ready = bp ? 1'b0 : 1'b1;
                default: out_ready = 1'b1;
            endcase
            tick();
            cycles++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, input_write_enable, start_bilstm, concat_mem_read_enable,
             out_valid, out_last, busy, run_done} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_strobes got %b want 00000000",
                     {in_ready, input_write_enable, start_bilstm, concat_mem_read_enable,
                      out_valid, out_last, busy, run_done});
        end
        n_cmp++;
        if (input_write_address !== '0 || input_write_data !== '0 || concat_mem_read_address !== '0) begin
            n_bad++;
            $display("FAIL reset_addr got wa=%0h wd=%0h ra=%0h want 0", input_write_address,
                     input_write_data, concat_mem_read_address);
        end
        n_cmp++;
        if (out_data !== '0 || batch_idx !== '0) begin
            n_bad++;
            $display("FAIL reset_out got data=%0h batch=%0d want 0", out_data, batch_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    // Batch 0 of a two-batch run, continuous input, out_ready held high
    task automatic test_single_batch();
        int sent, cyc;
        bit ok;
        clear_logs();
        pulse_run();
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || batch_idx !== '0) begin
            n_bad++;
            $display("FAIL run_accept got busy=%b rdy=%b batch=%0d want 1 1 0", busy, in_ready, batch_idx);
        end
        load_samples(1'b0, sent);
        wait_start(1, ok);
        n_cmp++;
        if (!ok || sent !== 60) begin
            n_bad++;
            $display("FAIL load_start got sent=%0d start=%0d want 60 1", sent, start_n);
        end
        n_cmp++;
        if (wr_n !== 60) begin n_bad++; $display("FAIL write_count got %0d want 60", wr_n); end
        for (int i = 0; i < 60; i++) begin
            n_cmp++;
            if (wr_addr_log[i] !== IAW'(i) || wr_data_log[i] !== DW'(i)) begin
                n_bad++;
                $display("FAIL write_%0d got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr_log[i],
                         wr_data_log[i], i, i);
            end
        end
        repeat (100) tick();
        n_cmp++;
        if (start_n !== 1 || iss_n !== 0) begin
            n_bad++;
            $display("FAIL wait_idle got start=%0d reads=%0d want 1 0", start_n, iss_n);
        end
        done_store_concat = 1'b1;
        drain(1'b0, 200, cyc);
        n_cmp++;
        if (cyc !== 203) begin n_bad++; $display("FAIL drain_latency got %0d cycles want 203", cyc); end
        for (int i = 0; i < 200; i++) begin
            n_cmp++;
            if (out_log[i] !== DW'(16'h100 + i) || last_log[i] !== (i == 199)) begin
                n_bad++;
                $display("FAIL out_%0d got %0h last=%b want %0h last=%b", i, out_log[i], last_log[i],
                         16'h100 + i, (i == 199));
            end
        end
        done_store_concat = 1'b0;
        tick();
        n_cmp++;
        if (iss_n !== 200 || max_out > 2) begin
            n_bad++;
            $display("FAIL read_issue got reads=%0d maxout=%0d want 200 <=2", iss_n, max_out);
        end
        n_cmp++;
        if (batch_idx !== BCW'(1) || in_ready !== 1'b1 || rdone_n !== 0) begin
            n_bad++;
            $display("FAIL next_batch got batch=%0d rdy=%b rdone=%0d want 1 1 0", batch_idx, in_ready, rdone_n);
        end
    endtask

    // Batch 1: idle cycles in the input stream, extra samples must be refused
    task automatic test_in_gaps();
        int sent;
        bit ok;
        int ready_seen;
        clear_logs();
        load_samples(1'b1, sent);
        n_cmp++;
        if (sent !== 60) begin n_bad++; $display("FAIL gaps_sent got %0d want 60", sent); end
        ready_seen = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = DW'(16'hBEEF);
            tick();
            if (beat_seen) ready_seen++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (ready_seen !== 0 || wr_n !== 60 || start_n !== 1) begin
            n_bad++;
            $display("FAIL gaps_extra got accepted=%0d writes=%0d start=%0d want 0 60 1",
                     ready_seen, wr_n, start_n);
        end
        for (int i = 0; i < 60; i++) begin
            n_cmp++;
            if (wr_addr_log[i] !== IAW'(i) || wr_data_log[i] !== DW'(i)) begin
                n_bad++;
                $display("FAIL gaps_write_%0d got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr_log[i],
                         wr_data_log[i], i, i);
            end
        end
        wait_start(1, ok);
    endtask

    // Batch 1 drain with out_ready pattern 1,0,0,1; final batch of the run
    task automatic test_backpressure();
        int cyc;
        repeat (5) tick();
        done_store_concat = 1'b1;
        drain(1'b1, 200, cyc);
        n_cmp++;
        if (out_n !== 200) begin n_bad++; $display("FAIL bp_count got %0d want 200", out_n); end
        for (int i = 0; i < 200; i++) begin
            n_cmp++;
            if (out_log[i] !== DW'(16'h100 + i) || last_log[i] !== (i == 199)) begin
                n_bad++;
                $display("FAIL bp_out_%0d got %0h last=%b want %0h last=%b", i, out_log[i], last_log[i],
                         16'h100 + i, (i == 199));
            end
        end
        n_cmp++;
        if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_bad); end
        n_cmp++;
        if (max_out > 2 || iss_n !== 200) begin
            n_bad++;
            $display("FAIL bp_outstanding got max=%0d reads=%0d want <=2 200", max_out, iss_n);
        end
        done_store_concat = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (rdone_n !== 1 || busy !== 1'b0 || batch_idx !== BCW'(2)) begin
            n_bad++;
            $display("FAIL run_done got pulses=%0d busy=%b batch=%0d want 1 0 2", rdone_n, busy, batch_idx);
        end
    endtask

    // done_store_concat left high from batch 0 must not start batch 1's drain
    task automatic test_stale_done();
        int sent, cyc, iss0;
        bit ok;
        clear_logs();
        pulse_run();
        load_samples(1'b0, sent);
        wait_start(1, ok);
        repeat (10) tick();
        done_store_concat = 1'b1;
        drain(1'b0, 200, cyc);
        load_samples(1'b0, sent);
        wait_start(2, ok);
        iss0 = iss_n;
        repeat (30) tick();
        n_cmp++;
        if (!ok || iss_n !== iss0 || out_n !== 200 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stale_hold got reads=%0d outs=%0d busy=%b want %0d 200 1", iss_n, out_n, busy, iss0);
        end
        done_store_concat = 1'b0;
        tick();
        done_store_concat = 1'b1;
        drain(1'b0, 400, cyc);
        done_store_concat = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_n !== 400 || last_n !== 2 || rdone_n !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_batches got outs=%0d lasts=%0d rdone=%0d busy=%b want 400 2 1 0",
                     out_n, last_n, rdone_n, busy);
        end
    endtask

    task automatic test_abort();
        int sent, cyc;
        bit ok;
        clear_logs();
        pulse_run();
        load_samples(1'b0, sent);
        wait_start(1, ok);
        repeat (5) tick();
        done_store_concat = 1'b1;
        drain(1'b0, 57, cyc);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || concat_mem_read_enable !== 1'b0 ||
            input_write_enable !== 1'b0 || start_bilstm !== 1'b0 || batch_idx !== '0) begin
            n_bad++;
            $display("FAIL abort_state got busy=%b ov=%b re=%b we=%b st=%b batch=%0d want all 0",
                     busy, out_valid, concat_mem_read_enable, input_write_enable, start_bilstm, batch_idx);
        end
        @(posedge clk);
        #1;
        clear_logs();
        repeat (3) tick();
        n_cmp++;
        if (out_n !== 0 || iss_n !== 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_flush got outs=%0d reads=%0d ov=%b want 0 0 0", out_n, iss_n, out_valid);
        end
        done_store_concat = 1'b0;
        pulse_run();
        n_cmp++;
        if (batch_idx !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_rerun got batch=%0d rdy=%b want 0 1", batch_idx, in_ready);
        end
        load_samples(1'b0, sent);
        wait_start(1, ok);
        n_cmp++;
        if (wr_n !== 60 || wr_addr_log[0] !== '0 || wr_data_log[0] !== '0) begin
            n_bad++;
            $display("FAIL abort_reload got writes=%0d a0=%0d d0=%0h want 60 0 0", wr_n,
                     wr_addr_log[0], wr_data_log[0]);
        end
    endtask

    // Reached while the sequencer sits in WAIT
    task automatic test_async_rst();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, input_write_enable, start_bilstm, concat_mem_read_enable,
             out_valid, out_last, busy, run_done} !== 8'h00 || batch_idx !== '0 ||
            input_write_address !== '0 || input_write_data !== '0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL async_rst got busy=%b wa=%0h wd=%0h od=%0h want all 0",
                     busy, input_write_address, input_write_data, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_run();
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || batch_idx !== '0) begin
            n_bad++;
            $display("FAIL rst_rerun got busy=%b rdy=%b batch=%0d want 1 1 0", busy, in_ready, batch_idx);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single_batch();
        test_in_gaps();
        test_backpressure();
        test_stale_done();
        test_abort();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
